// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the device.
// The PS/2 lines are driven open-drain through the output enables. The top level
// pulls a line to 0 while its enable is high and leaves it high-Z otherwise.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   tx_data/tx_valid  command byte and send request
//   tx_ready          high only when idle; the byte is taken on tx_valid && tx_ready
//   ps2_clk_in        raw PS/2 clock pin level (asynchronous)
//   ps2_data_in       raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe        1 = pull the PS/2 clock line low
//   ps2_data_oe       1 = pull the PS/2 data line low
//   busy              a transfer is in progress
//   done              one-cycle pulse when the device ACKs the byte
//   error             one-cycle pulse on timeout or NACK
module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam longint unsigned InhCyc64 = (64'(INHIBIT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam longint unsigned ToCyc64  = (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned InhCyc = int'(InhCyc64);
  localparam int unsigned ToCyc  = int'(ToCyc64);
  localparam int unsigned InhW   = $clog2(InhCyc + 1);
  localparam int unsigned ToW    = $clog2(ToCyc + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(InhCyc - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(ToCyc);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [7:0]      shreg_q;
  logic            parity_q;
  logic [3:0]      bitcnt_q;
  logic            dbit_q;
  logic [InhW-1:0] icnt_q;
  logic [ToW-1:0]  tcnt_q;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall, timeout, active;

  // Synchronisers reset to the idle (released, pulled-up) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign active  = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign timeout = active && (tcnt_q == ToLast);

  // Next state and completion pulses; a timeout overrides any edge in the same cycle.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    error   = 1'b0;
    unique case (state_q)
      IDLE:    if (tx_valid) state_d = INHIBIT;
      INHIBIT: if (icnt_q == InhLast) state_d = REQ;
      REQ:     state_d = SEND;
      SEND: begin
        if (timeout) begin
          error   = 1'b1;
          state_d = IDLE;
        end else if (fall && bitcnt_q == 4'd9) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (timeout) begin
          error   = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          if (!data_sync_q) begin
            state_d = WAIT_IDLE;
          end else begin
            error   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (timeout) begin
          error   = 1'b1;
          state_d = IDLE;
        end else if (clk_sync_q && data_sync_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      bitcnt_q <= '0;
      dbit_q   <= 1'b0;
      icnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && tx_valid) begin
        shreg_q  <= tx_data;
        parity_q <= ~^tx_data;
      end

      if (state_q == INHIBIT) icnt_q <= icnt_q + 1'b1;
      else                    icnt_q <= '0;

      // Counter stops at ToLast because the FSM leaves the active states there.
      if (active) tcnt_q <= tcnt_q + 1'b1;
      else        tcnt_q <= '0;

      if (state_q == REQ) begin
        bitcnt_q <= '0;
        dbit_q   <= 1'b1;  // start bit keeps data low after the clock is released
      end else if (state_q == SEND && fall) begin
        bitcnt_q <= bitcnt_q + 1'b1;
        if (bitcnt_q < 4'd8)       dbit_q <= ~shreg_q[bitcnt_q[2:0]];
        else if (bitcnt_q == 4'd8) dbit_q <= ~parity_q;
        else                       dbit_q <= 1'b0;  // stop bit: release the line
      end
    end
  end

  // Line enables decode from state registers only, so reset releases them at once.
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2_data_oe = (state_q == REQ) || ((state_q == SEND) && dbit_q);
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk, ps2_data;

  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, clk_oe2, data_oe2, busy2, done2, error2;
  logic       ps2_clk2, ps2_data2;

  assign ps2_clk   = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data  = ~(ps2_data_oe | dev_data_low);
  assign ps2_clk2  = ~clk_oe2;
  assign ps2_data2 = ~data_oe2;

  always #5 clk = ~clk;

  ps2_host_tx dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk),
    .ps2_data_in(ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Device that never clocks; short timeout.
  ps2_host_tx #(.TIMEOUT_US(100)) dut_to (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .ps2_clk_in (ps2_clk2),
    .ps2_data_in(ps2_data2),
    .ps2_clk_oe (clk_oe2),
    .ps2_data_oe(data_oe2),
    .busy       (busy2),
    .done       (done2),
    .error      (error2)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [10:0] exp_frames[$];

  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;
  logic busy_at_done = 1'b0, busy_after_done = 1'b1, rel_after_err = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
    end
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if (tx_valid && tx_ready) acc_cnt++;
    if (done_prev) busy_after_done = busy;
    if (err_prev) rel_after_err = !ps2_clk_oe && !ps2_data_oe && tx_ready;
    done_prev = done;
    err_prev  = error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one request; the expected frame goes to the scoreboard now.
  task automatic start_tx(input logic [7:0] d, input bit keep_valid);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_frames.push_back({1'b1, ~^d, d, 1'b0});
    @(posedge clk);
    #1;
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  // Device model: waits for the request-to-send, clocks the frame in, then ACKs or NACKs.
  // abort_at = k stops after k-1 clock pulses with the device lines released.
  task automatic dev_xfer(input bit ack, input int abort_at, output int inh);
    logic [10:0] frame;
    logic [10:0] exp;
    bit seen;
    inh = 0;
    seen = 0;
    frame = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      if (!ps2_clk_oe && ps2_data_oe) begin
        seen = 1;
        break;
      end
    end
    check("reach_send", 32'(seen), 32'd1);
    if (!seen) return;
    repeat (5) @(negedge clk);
    frame[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      if (i == abort_at) return;
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      frame[i] = ps2_data;
      repeat (10) @(negedge clk);
    end
    if (exp_frames.size() == 0) begin
      check("frame_queue", 32'd0, 32'd1);
    end else begin
      exp = exp_frames.pop_front();
      check("frame", 32'(frame), 32'(exp));
    end
    dev_data_low = ack;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic run_case(input logic [7:0] d, input bit ack, input string tag);
    int d0, e0, inh;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d, 1'b0);
    dev_xfer(ack, 11, inh);
    repeat (60) @(negedge clk);
    check({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
  endtask

  initial begin
    int d0, e0, a0, inh, n;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_pulses", 32'({done, error}), 32'd0);
    check("rst_ready_to", 32'(tx_ready2), 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED with a timed inhibit phase and done/busy relationship.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED, 1'b0);
    dev_xfer(1'b1, 11, inh);
    check("inhibit_cycles", 32'(inh), 32'd2500);
    repeat (60) @(negedge clk);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_err", 32'(err_cnt - e0), 32'd0);
    check("ed_busy_at_done", 32'(busy_at_done), 32'd1);
    check("ed_busy_after_done", 32'(busy_after_done), 32'd0);

    run_case(8'hF4, 1'b1, "f4");

    // NACK
    run_case(8'h55, 1'b0, "nack");
    check("nack_released", 32'(rel_after_err), 32'd1);

    // Timeout on the silent device.
    @(negedge clk);
    tx_data2  = 8'hED;
    tx_valid2 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid2 = 1'b0;
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!clk_oe2 && data_oe2) begin
        seen = 1;
        break;
      end
    end
    check("to_reach_send", 32'(seen), 32'd1);
    n = 0;
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      n++;
      if (error2) begin
        seen = 1;
        break;
      end
    end
    check("to_err_seen", 32'(seen), 32'd1);
    check("to_cycles", 32'(n), 32'd2500);
    @(negedge clk);
    check("to_released", 32'({clk_oe2, data_oe2, error2}), 32'd0);
    check("to_ready", 32'(tx_ready2), 32'd1);

    // Asynchronous reset in the middle of the data bits.
    start_tx(8'h00, 1'b0);
    dev_xfer(1'b1, 5, inh);
    check("mid_data_low", 32'(ps2_data_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_async_ready", 32'(tx_ready), 32'd1);
    void'(exp_frames.pop_front());
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_case(8'hFF, 1'b1, "ff_after_rst");

    // tx_valid held through a transfer with a different byte.
    d0 = done_cnt;
    a0 = acc_cnt;
    start_tx(8'hA5, 1'b1);
    tx_data = 8'h3C;
    exp_frames.push_back({1'b1, ~^tx_data, tx_data, 1'b0});
    dev_xfer(1'b1, 11, inh);
    check("hold_acc_first", 32'(acc_cnt - a0), 32'd1);
    repeat (60) @(negedge clk);
    check("hold_done_first", 32'(done_cnt - d0), 32'd1);
    check("hold_acc_second", 32'(acc_cnt - a0), 32'd2);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 11, inh);
    repeat (60) @(negedge clk);
    check("hold_done_second", 32'(done_cnt - d0), 32'd2);

    check("done_err_overlap", 32'(both_cnt), 32'd0);
    check("queue_empty", 32'(exp_frames.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
